// File: rtl/bmaxpool_stream.sv
// Streaming binary max/min pool: one CH-bit pixel per beat in raster order, one pooled
// pixel per completed POOLxPOOL window, valid/ready on both sides.
module bmaxpool_stream #(
  parameter int unsigned I_W     = 26,
  parameter int unsigned I_H     = 26,
  parameter int unsigned CH      = 1,
  parameter int unsigned POOL    = 2,
  parameter int unsigned POOL_OP = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [CH-1:0] in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [CH-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_last
);

  localparam int unsigned O_W       = I_W / POOL;
  localparam int unsigned O_H       = I_H / POOL;
  localparam int unsigned ROWS_USED = O_H * POOL;
  localparam int unsigned CW        = $clog2(I_W + 1);
  localparam int unsigned RW        = $clog2(I_H + 1);
  localparam int unsigned PW        = (POOL > 1) ? $clog2(POOL) : 1;
  localparam int unsigned OXW       = $clog2(O_W + 1);
  localparam int unsigned AW        = (O_W > 1) ? $clog2(O_W) : 1;

  logic [CW-1:0]  col_q, col_d;
  logic [RW-1:0]  row_q, row_d;
  logic [PW-1:0]  px_q, px_d;
  logic [PW-1:0]  py_q, py_d;
  logic [OXW-1:0] ox_q, ox_d;
  logic [CH-1:0]  acc_q [O_W];
  logic [CH-1:0]  out_data_q, out_data_d;
  logic           out_valid_q, out_valid_d;
  logic           out_last_q, out_last_d;

  logic           accept;
  logic           in_window;
  logic           win_first;
  logic           win_last;
  logic [CH-1:0]  acc_rd;
  logic [CH-1:0]  acc_op;
  logic [CH-1:0]  pix_val;

  assign in_ready  = !out_valid_q || out_ready;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;

  // Window bookkeeping; the first pixel of a window replaces stale accumulator contents.
  always_comb begin
    accept    = in_valid && in_ready;
    in_window = (ox_q < OXW'(O_W)) && (row_q < RW'(ROWS_USED));
    win_first = (px_q == '0) && (py_q == '0);
    win_last  = (px_q == PW'(POOL - 1)) && (py_q == PW'(POOL - 1));
    acc_rd    = acc_q[AW'(ox_q)];
    acc_op    = (POOL_OP != 0) ? (acc_rd & in_data) : (acc_rd | in_data);
    pix_val   = win_first ? in_data : acc_op;
  end

  // Raster position counters; ox saturates at O_W over the cropped right margin.
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    px_d  = px_q;
    py_d  = py_q;
    ox_d  = ox_q;
    if (accept) begin
      if (col_q == CW'(I_W - 1)) begin
        col_d = '0;
        px_d  = '0;
        ox_d  = '0;
        if (row_q == RW'(I_H - 1)) begin
          row_d = '0;
          py_d  = '0;
        end else begin
          row_d = row_q + RW'(1);
          py_d  = (py_q == PW'(POOL - 1)) ? '0 : py_q + PW'(1);
        end
      end else begin
        col_d = col_q + CW'(1);
        if (px_q == PW'(POOL - 1)) begin
          px_d = '0;
          if (ox_q != OXW'(O_W)) ox_d = ox_q + OXW'(1);
        end else begin
          px_d = px_q + PW'(1);
        end
      end
    end
  end

  // Output register: a completing window overrides a same-edge drain, so no bubble.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end
    if (accept && in_window && win_last) begin
      out_valid_d = 1'b1;
      out_data_d  = pix_val;
      out_last_d  = (ox_q == OXW'(O_W - 1)) && (row_q == RW'(ROWS_USED - 1));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q       <= '0;
      row_q       <= '0;
      px_q        <= '0;
      py_q        <= '0;
      ox_q        <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      px_q        <= px_d;
      py_q        <= py_d;
      ox_q        <= ox_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept && in_window) acc_q[AW'(ox_q)] <= pix_val;
  end

endmodule

// File: tb/tb_bmaxpool_stream.sv
// Directed bench for bmaxpool_stream: three configurations (4x4 OR, 4x4 AND, 5x5 CH=4 OR)
// driven one at a time, each beat checked against hand-computed window results.
module tb_bmaxpool_stream;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] in_data;
  logic       in_valid;
  logic       out_ready;
  int         sel;

  logic       rdy_a, ov_a, ol_a;
  logic [0:0] od_a;
  logic       rdy_b, ov_b, ol_b;
  logic [0:0] od_b;
  logic       rdy_c, ov_c, ol_c;
  logic [3:0] od_c;

  logic       obs_ready, obs_valid, obs_last;
  logic [3:0] obs_data;

  logic [3:0] frame   [25];
  logic [3:0] exp_out [4];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  bmaxpool_stream #(.I_W(4), .I_H(4), .CH(1), .POOL(2), .POOL_OP(0)) dut_a (
    .clk(clk), .rst(rst), .in_data(in_data[0:0]), .in_valid(in_valid && sel == 0),
    .in_ready(rdy_a), .out_data(od_a), .out_valid(ov_a), .out_ready(out_ready), .out_last(ol_a));

  bmaxpool_stream #(.I_W(4), .I_H(4), .CH(1), .POOL(2), .POOL_OP(1)) dut_b (
    .clk(clk), .rst(rst), .in_data(in_data[0:0]), .in_valid(in_valid && sel == 1),
    .in_ready(rdy_b), .out_data(od_b), .out_valid(ov_b), .out_ready(out_ready), .out_last(ol_b));

  bmaxpool_stream #(.I_W(5), .I_H(5), .CH(4), .POOL(2), .POOL_OP(0)) dut_c (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid && sel == 2),
    .in_ready(rdy_c), .out_data(od_c), .out_valid(ov_c), .out_ready(out_ready), .out_last(ol_c));

  always_comb begin
    case (sel)
      0:       begin obs_ready = rdy_a; obs_valid = ov_a; obs_last = ol_a; obs_data = {3'b000, od_a}; end
      1:       begin obs_ready = rdy_b; obs_valid = ov_b; obs_last = ol_b; obs_data = {3'b000, od_b}; end
      default: begin obs_ready = rdy_c; obs_valid = ov_c; obs_last = ol_c; obs_data = od_c; end
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Streams nbeats of frame[] into the selected instance; a small model of the
  // handshake predicts in_ready/out_valid each cycle and picks data from exp_out[].
  task automatic run(input string tag, input int w, input int h, input int stall,
                     input int nbeats, input bit gaps, input int exp_n);
    int   pix   = 0;
    int   nobs  = 0;
    int   nlast = 0;
    int   cyc   = 0;
    bit   mv    = 1'b0;
    logic [3:0] md = '0;
    bit   ml    = 1'b0;
    bit   exp_rdy, drain, acc;
    int   r, c, idx;
    @(negedge clk);
    while (cyc < 200 && (pix < nbeats || mv)) begin
      out_ready = (cyc >= stall);
      in_valid  = (pix < nbeats) && !(gaps && (cyc % 3 == 2));
      in_data   = (pix < nbeats) ? frame[pix] : 4'h0;
      #1;
      exp_rdy = !mv || out_ready;
      check({tag, ".in_ready"}, 32'(obs_ready), 32'(exp_rdy));
      if (obs_valid && out_ready) begin
        nobs++;
        if (obs_last) nlast++;
      end
      drain = mv && out_ready;
      acc   = in_valid && exp_rdy;
      if (drain) mv = 1'b0;
      if (acc) begin
        r = pix / w;
        c = pix % w;
        if (r < (h / 2) * 2 && c < (w / 2) * 2 && (r % 2 == 1) && (c % 2 == 1)) begin
          idx = (r / 2) * (w / 2) + c / 2;
          mv  = 1'b1;
          md  = exp_out[idx];
          ml  = (idx == 3);
        end
        pix++;
      end
      @(negedge clk);
      check({tag, ".out_valid"}, 32'(obs_valid), 32'(mv));
      if (mv) begin
        check({tag, ".out_data"}, 32'(obs_data), 32'(md));
        check({tag, ".out_last"}, 32'(obs_last), 32'(ml));
      end
      cyc++;
    end
    in_valid = 1'b0;
    check({tag, ".done"}, 32'(pix >= nbeats && !mv), 32'd1);
    check({tag, ".n_out"}, 32'(nobs), 32'(exp_n));
    check({tag, ".n_last"}, 32'(nlast), 32'(exp_n == 4 ? 1 : 0));
  endtask

  task automatic clear_frame();
    for (int i = 0; i < 25; i++) frame[i] = 4'h0;
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 4'h0;
    out_ready = 1'b0;
    sel       = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      check("reset.out_valid", 32'(obs_valid), 32'd0);
      check("reset.out_data", 32'(obs_data), 32'd0);
      check("reset.out_last", 32'(obs_last), 32'd0);
      check("reset.in_ready", 32'(obs_ready), 32'd1);
    end

    // 4x4 OR, single 1 at (1,2)
    sel = 0;
    clear_frame();
    frame[6] = 4'h1;
    exp_out  = '{4'h0, 4'h1, 4'h0, 4'h0};
    run("or4x4", 4, 4, 0, 16, 1'b0, 4);

    // 4x4 AND, all ones except (3,3)
    sel = 1;
    for (int i = 0; i < 16; i++) frame[i] = 4'h1;
    frame[15] = 4'h0;
    exp_out   = '{4'h1, 4'h1, 4'h1, 4'h0};
    run("and4x4", 4, 4, 0, 16, 1'b0, 4);

    // 5x5 CH=4, last row/column cropped; second frame back-to-back with input gaps
    sel = 2;
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++)
        frame[r * 5 + c] = (r == 4 || c == 4) ? 4'h0 : 4'hF;
    exp_out = '{4'hF, 4'hF, 4'hF, 4'hF};
    run("crop5x5.f0", 5, 5, 0, 25, 1'b0, 4);
    run("crop5x5.f1", 5, 5, 0, 25, 1'b1, 4);

    // Backpressure: out_ready low for the first 10 cycles, 1s at (0,0) and (2,3)
    sel = 0;
    clear_frame();
    frame[0]  = 4'h1;
    frame[11] = 4'h1;
    exp_out   = '{4'h1, 4'h0, 4'h0, 4'h1};
    run("bp4x4", 4, 4, 10, 16, 1'b0, 4);

    // Partial frame of 7 beats, reset, then a full frame with gaps
    clear_frame();
    frame[6] = 4'h1;
    exp_out  = '{4'h0, 4'h1, 4'h0, 4'h0};
    run("partial", 4, 4, 0, 7, 1'b0, 1);
    rst = 1'b1;
    @(negedge clk);
    rst       = 1'b0;
    out_ready = 1'b0;
    #1;
    check("midrst.out_valid", 32'(obs_valid), 32'd0);
    check("midrst.out_last", 32'(obs_last), 32'd0);
    check("midrst.in_ready", 32'(obs_ready), 32'd1);
    run("after_rst", 4, 4, 0, 16, 1'b1, 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
